// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC point-arithmetic slice: scalar width,
// width-mode and command encodings.
package ecc_pkg;

  localparam int unsigned MAX_BITS = 256;

  typedef enum logic [1:0] {
    BITS32  = 2'b00,
    BITS64  = 2'b01,
    BITS128 = 2'b10,
    BITS256 = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LOAD = 2'b01,
    OP_DBL  = 2'b10,
    OP_ADD  = 2'b11
  } op_t;

  function automatic logic [8:0] mode_to_width(input logic [1:0] mode);
    logic [8:0] w;
    case (mode_t'(mode))
      BITS32:  w = 9'd32;
      BITS64:  w = 9'd64;
      BITS128: w = 9'd128;
      default: w = 9'd256;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Command channel between the scalar-mult sequencer (master) and the
// point add/double datapath (slave).
interface ecc_scalar_mult_ctrl_if;

  logic       op_valid;
  logic [1:0] op;
  logic       dummy;
  logic       op_ready;
  logic       op_done;

  modport master (
    output op_valid, op, dummy,
    input  op_ready, op_done
  );

  modport slave (
    input  op_valid, op, dummy,
    output op_ready, op_done
  );

endinterface

// File: rtl/ecc_scalar_mult_ctrl_op_issue.sv
// Command holding register: keeps valid/op/dummy stable until accepted,
// then tracks the outstanding command until the datapath reports done.
module ecc_op_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [1:0] issue_op,
  input  logic       issue_dummy,
  output logic       accepted,
  output logic       complete,
  output logic [1:0] cur_op,
  ecc_scalar_mult_ctrl_if.master bus
);
  import ecc_pkg::*;

  logic waiting;

  assign accepted = bus.op_valid && bus.op_ready;
  assign complete = waiting && bus.op_done;
  assign cur_op   = bus.op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.op_valid <= 1'b0;
      bus.op       <= OP_NONE;
      bus.dummy    <= 1'b0;
      waiting      <= 1'b0;
    end else begin
      if (issue) begin
        bus.op_valid <= 1'b1;
        bus.op       <= issue_op;
        bus.dummy    <= issue_dummy;
      end else if (accepted) begin
        bus.op_valid <= 1'b0;
        waiting      <= 1'b1;
      end
      if (complete) waiting <= 1'b0;
    end
  end

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for scalar multiplication mP.
// Define ECC_CONST_TIME_EN to issue an ADD (dummy on zero bits) after every DBL.
module ecc_scalar_mult_ctrl #(
  parameter int unsigned MAX_BITS = ecc_pkg::MAX_BITS,
  parameter int unsigned IDX_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [MAX_BITS-1:0] i_m,
  output logic                o_busy,
  ecc_scalar_mult_ctrl_if.master bus,
  output logic [IDX_W-1:0]    o_bit_idx,
  output logic                o_done,
  output logic                o_inf
);
  import ecc_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [MAX_BITS-1:0] m_q;
  logic [IDX_W-1:0]    idx;

  logic       accepted, complete;
  logic [1:0] cur_op;
  logic       issue_req, issue_dummy;
  logic [1:0] issue_op;
  logic       step_done, step_issue, step_dec, step_dummy;
  logic [1:0] step_op;
  logic       bit_set, idx_zero;

  assign bit_set   = m_q[idx];
  assign idx_zero  = (idx == '0);
  assign o_bit_idx = idx;

  // Next step after a completed command, decided from the op that just finished.
  always_comb begin
    step_done  = 1'b0;
    step_issue = 1'b0;
    step_dec   = 1'b0;
    step_dummy = 1'b0;
    step_op    = OP_DBL;
    if (state == S_WAIT && complete) begin
      if (cur_op == OP_DBL) begin
`ifdef ECC_CONST_TIME_EN
        step_issue = 1'b1;
        step_op    = OP_ADD;
        step_dummy = !bit_set;
`else
        if (bit_set) begin
          step_issue = 1'b1;
          step_op    = OP_ADD;
        end else if (idx_zero) begin
          step_done = 1'b1;
        end else begin
          step_dec   = 1'b1;
          step_issue = 1'b1;
        end
`endif
      end else if (idx_zero) begin
        step_done = 1'b1;
      end else begin
        step_dec   = 1'b1;
        step_issue = 1'b1;
      end
    end
  end

  // The issue register loads on the same edge the FSM enters ISSUE, so valid
  // appears with no extra cycle.
  assign issue_req   = (state == S_SCAN && bit_set) || step_issue;
  assign issue_op    = (state == S_SCAN) ? OP_LOAD : step_op;
  assign issue_dummy = step_dummy;

  ecc_op_issue u_issue (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue_req),
    .issue_op    (issue_op),
    .issue_dummy (issue_dummy),
    .accepted    (accepted),
    .complete    (complete),
    .cur_op      (cur_op),
    .bus         (bus)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      m_q    <= '0;
      idx    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_inf  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            m_q    <= i_m;
            idx    <= IDX_W'(mode_to_width(i_mode) - 9'd1);
            o_inf  <= 1'b0;
            o_busy <= 1'b1;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (bit_set) begin
            state <= S_ISSUE;
          end else if (idx_zero) begin
            o_inf  <= 1'b1;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        S_ISSUE: begin
          if (accepted) state <= S_WAIT;
        end
        S_WAIT: begin
          if (step_done) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end else if (step_issue) begin
            state <= S_ISSUE;
          end
          if (step_dec) idx <= idx - IDX_W'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Directed bench for ecc_scalar_mult_ctrl with a simple datapath responder
// (done two cycles after acceptance, optional ready stall on DBL).
module tb_ecc_scalar_mult_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [1:0]   i_mode;
  logic [255:0] i_m;
  logic         o_busy;
  logic [7:0]   o_bit_idx;
  logic         o_done;
  logic         o_inf;

  ecc_scalar_mult_ctrl_if bus();

  ecc_scalar_mult_ctrl #(.MAX_BITS(256), .IDX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_m       (i_m),
    .o_busy    (o_busy),
    .bus       (bus),
    .o_bit_idx (o_bit_idx),
    .o_done    (o_done),
    .o_inf     (o_inf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] ops[$];
  logic       dums[$];
  int         done_cnt;
  int         valid_cycles;
  int         dbl_valid_cycles;
  int         stall_left = 0;
  int         pend = 0;
  logic       inf_at_done;
  longint     start_t, first_valid_t, done_t;

  // Datapath responder and monitor, all activity at the falling edge.
  initial begin
    bus.op_ready = 1'b1;
    bus.op_done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.op_done = 1'b0;
      if (!rst) begin
        pend = 0;
        bus.op_ready = 1'b1;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) bus.op_done = 1'b1;
        end
        if (bus.op_valid && bus.op == 2'b10 && stall_left > 0) begin
          bus.op_ready = 1'b0;
          stall_left--;
        end else begin
          bus.op_ready = 1'b1;
        end
        if (bus.op_valid) begin
          valid_cycles++;
          if (first_valid_t < 0) first_valid_t = $time;
          if (bus.op == 2'b10) dbl_valid_cycles++;
        end
        if (bus.op_valid && bus.op_ready) begin
          ops.push_back(bus.op);
          dums.push_back(bus.dummy);
          pend = 2;
        end
        if (o_done) begin
          done_cnt++;
          done_t = $time;
          inf_at_done = o_inf;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic clear_obs();
    ops.delete();
    dums.delete();
    done_cnt = 0;
    valid_cycles = 0;
    dbl_valid_cycles = 0;
    first_valid_t = -1;
    done_t = -1;
  endtask

  task automatic pulse_start(input logic [1:0] mode, input logic [255:0] m);
    @(negedge clk);
    i_mode = mode;
    i_m = m;
    i_start = 1'b1;
    start_t = $time;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run(input logic [1:0] mode, input logic [255:0] m);
    clear_obs();
    pulse_start(mode, m);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_start = 1'b0;
    i_mode = 2'b00;
    i_m = '0;
    clear_obs();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.op_valid); end
    checks++; if (bus.op !== 2'b00) begin errors++; $display("FAIL reset_op got %0d exp 0", bus.op); end
    checks++; if (o_bit_idx !== 8'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", o_bit_idx); end
    checks++; if ({o_done, o_inf, bus.dummy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {o_done, o_inf, bus.dummy}); end
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_m5();
    logic [1:0] exp_ops[$];
    logic       exp_dum[$];
`ifdef ECC_CONST_TIME_EN
    exp_ops = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    exp_dum = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    exp_ops = '{2'd1, 2'd2, 2'd2, 2'd3};
    exp_dum = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    clear_obs();
    pulse_start(2'b00, 256'd5);
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL m5_busy got %b exp 1", o_busy); end
    for (int i = 0; i < 1000 && done_cnt == 0; i++) begin @(negedge clk); #1; end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ops.size() !== exp_ops.size()) begin errors++; $display("FAIL m5_count got %0d exp %0d", ops.size(), exp_ops.size()); end
    for (int i = 0; i < exp_ops.size() && i < ops.size(); i++) begin
      checks++; if (ops[i] !== exp_ops[i]) begin errors++; $display("FAIL m5_op[%0d] got %0d exp %0d", i, ops[i], exp_ops[i]); end
      checks++; if (dums[i] !== exp_dum[i]) begin errors++; $display("FAIL m5_dummy[%0d] got %b exp %b", i, dums[i], exp_dum[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL m5_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (inf_at_done !== 1'b0) begin errors++; $display("FAIL m5_inf got %b exp 0", inf_at_done); end
    // start edge + 29 skipped zeros + the cycle that finds bit 2
    checks++; if (first_valid_t - start_t !== 64'(31 * 10)) begin errors++; $display("FAIL m5_scan_lat got %0d exp 310", first_valid_t - start_t); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL m5_busy_end got %b exp 0", o_busy); end
  endtask

  task automatic test_zero();
    run(2'b00, 256'd0);
    checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", valid_cycles); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (inf_at_done !== 1'b1) begin errors++; $display("FAIL zero_inf got %b exp 1", inf_at_done); end
    checks++; if (done_t - start_t !== 64'(33 * 10)) begin errors++; $display("FAIL zero_lat got %0d exp 330", done_t - start_t); end
    checks++; if (o_inf !== 1'b1) begin errors++; $display("FAIL zero_inf_hold got %b exp 1", o_inf); end
  endtask

  task automatic test_upper_ignored();
    logic [255:0] m;
    logic [1:0]   exp_ops[$];
    m = '0;
    m[32] = 1'b1;
    m[1:0] = 2'b11;
    exp_ops = '{2'd1, 2'd2, 2'd3};
    run(2'b00, m);
    checks++; if (ops.size() !== 3) begin errors++; $display("FAIL upper_count got %0d exp 3", ops.size()); end
    for (int i = 0; i < 3 && i < ops.size(); i++) begin
      checks++; if (ops[i] !== exp_ops[i]) begin errors++; $display("FAIL upper_op[%0d] got %0d exp %0d", i, ops[i], exp_ops[i]); end
    end
    checks++; if (o_inf !== 1'b0) begin errors++; $display("FAIL upper_inf got %b exp 0", o_inf); end
  endtask

  task automatic test_stall();
    stall_left = 3;
    run(2'b00, 256'd2);
    checks++; if (stall_left !== 0) begin errors++; $display("FAIL stall_used got %0d exp 0", stall_left); end
    checks++; if (dbl_valid_cycles !== 4) begin errors++; $display("FAIL stall_dbl_valid got %0d exp 4", dbl_valid_cycles); end
`ifdef ECC_CONST_TIME_EN
    checks++; if (ops.size() !== 3) begin errors++; $display("FAIL stall_count got %0d exp 3", ops.size()); end
    checks++; if (valid_cycles !== 6) begin errors++; $display("FAIL stall_valid got %0d exp 6", valid_cycles); end
`else
    checks++; if (ops.size() !== 2) begin errors++; $display("FAIL stall_count got %0d exp 2", ops.size()); end
    checks++; if (valid_cycles !== 5) begin errors++; $display("FAIL stall_valid got %0d exp 5", valid_cycles); end
`endif
    if (ops.size() >= 2) begin
      checks++; if (ops[1] !== 2'd2) begin errors++; $display("FAIL stall_op1 got %0d exp 2", ops[1]); end
    end
  endtask

  task automatic test_full_width();
    logic [255:0] m;
    int dbl_n, add_n, dum_n;
    m = '0;
    m[255] = 1'b1;
    m[0] = 1'b1;
    run(2'b11, m);
    dbl_n = 0; add_n = 0; dum_n = 0;
    foreach (ops[i]) begin
      if (ops[i] == 2'd2) dbl_n++;
      if (ops[i] == 2'd3) add_n++;
      if (dums[i]) dum_n++;
    end
    checks++; if (dbl_n !== 255) begin errors++; $display("FAIL full_dbl got %0d exp 255", dbl_n); end
`ifdef ECC_CONST_TIME_EN
    checks++; if (add_n !== 255) begin errors++; $display("FAIL full_add got %0d exp 255", add_n); end
    checks++; if (dum_n !== 254) begin errors++; $display("FAIL full_dummy got %0d exp 254", dum_n); end
`else
    checks++; if (add_n !== 1) begin errors++; $display("FAIL full_add got %0d exp 1", add_n); end
    checks++; if (dum_n !== 0) begin errors++; $display("FAIL full_dummy got %0d exp 0", dum_n); end
`endif
    checks++; if (first_valid_t - start_t !== 64'(2 * 10)) begin errors++; $display("FAIL full_lat got %0d exp 20", first_valid_t - start_t); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    pulse_start(2'b01, 256'hFF);
    for (int i = 0; i < 500 && ops.size() < 2; i++) begin @(negedge clk); #1; end
    checks++; if (ops.size() < 2) begin errors++; $display("FAIL rmid_progress got %0d exp 2", ops.size()); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", o_busy); end
    checks++; if (o_bit_idx !== 8'd0) begin errors++; $display("FAIL rmid_idx got %0d exp 0", o_bit_idx); end
    checks++; if ({bus.op_valid, bus.op, o_done} !== 4'b0000) begin errors++; $display("FAIL rmid_cmd got %b exp 0000", {bus.op_valid, bus.op, o_done}); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", done_cnt); end
    checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle_valid got %b exp 0", bus.op_valid); end
    run(2'b00, 256'd1);
    checks++; if (ops.size() !== 1) begin errors++; $display("FAIL rmid_new_count got %0d exp 1", ops.size()); end
    if (ops.size() >= 1) begin
      checks++; if (ops[0] !== 2'd1) begin errors++; $display("FAIL rmid_new_op got %0d exp 1", ops[0]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rmid_new_done got %0d exp 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_m5();
    test_zero();
    test_upper_ignored();
    test_stall();
    test_full_width();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
